// File: rtl/ascii_seg_display.sv
// ascii_seg_display
//   Drives a 2-digit multiplexed, active-low seven-segment display from a
//   two-character ASCII value. The value is copied into a shadow register
//   once per frame, so the two digits of a frame always belong together.
//   Characters other than '0'-'9', ' ' and '-' are shown blank and flagged
//   on err.
//
//   Optional feature macro: BLINK_ON_DONE_EN
//     When defined, the display blinks while done=1. Each half-phase lasts
//     BLINK_DIV frames. When undefined, done is ignored.
//
// Ports
//   clock     in   1  system clock, rising edge
//   reset     in   1  asynchronous, active-high reset
//   ascii_in  in  16  [15:8] tens character, [7:0] units character
//   done      in   1  counter finished flag (used only by the blink logic)
//   seg       out  7  active-low segments {g,f,e,d,c,b,a}
//   an        out  2  active-low digit enables, an[1]=tens, an[0]=units
//   err       out  1  latched frame contains an undisplayable character
module ascii_seg_display #(
    parameter int REFRESH_DIV = 4,
    parameter int BLINK_DIV   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ascii_in,
    input  logic        done,
    output logic [6:0]  seg,
    output logic [1:0]  an,
    output logic        err
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    // Returns {illegal, segments}; illegal codes decode to blank.
    function automatic logic [7:0] decode_char(input logic [7:0] c);
        logic [7:0] r;
        case (c)
            8'h30:   r = {1'b0, 7'b1000000};
            8'h31:   r = {1'b0, 7'b1111001};
            8'h32:   r = {1'b0, 7'b0100100};
            8'h33:   r = {1'b0, 7'b0110000};
            8'h34:   r = {1'b0, 7'b0011001};
            8'h35:   r = {1'b0, 7'b0010010};
            8'h36:   r = {1'b0, 7'b0000010};
            8'h37:   r = {1'b0, 7'b1111000};
            8'h38:   r = {1'b0, 7'b0000000};
            8'h39:   r = {1'b0, 7'b0010000};
            8'h20:   r = {1'b0, 7'b1111111};
            8'h2D:   r = {1'b0, 7'b0111111};
            default: r = {1'b1, 7'b1111111};
        endcase
        return r;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic             sel;
    logic             frame_start;
    logic [15:0]      shadow;
    logic             slot_end;
    logic             frame_end;
    logic             blank;

    logic [7:0]       dec_tens;
    logic [7:0]       dec_units;
    logic [6:0]       seg_nxt;
    logic [1:0]       an_nxt;
    logic             err_nxt;

    assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
    // Units slot ending: sel goes 1->0 and the next frame begins.
    assign frame_end = slot_end & sel;

    always_comb begin
        dec_tens  = decode_char(shadow[15:8]);
        dec_units = decode_char(shadow[7:0]);
        seg_nxt   = sel ? dec_units[6:0] : dec_tens[6:0];
        an_nxt    = sel ? 2'b10 : 2'b01;
        err_nxt   = dec_tens[7] | dec_units[7];
    end

`ifdef BLINK_ON_DONE_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (!done) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Gated with the live done so the edge that sees done fall is already lit.
    assign blank = blink_off & done;
`else
    logic unused_blink;
    localparam int UNUSED_BLINK_DIV = BLINK_DIV;
    assign unused_blink = done ^ (UNUSED_BLINK_DIV == 0);
    assign blank        = 1'b0;
`endif

    // Scan / frame latch stage -> registered output stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            sel         <= 1'b0;
            frame_start <= 1'b1;
            shadow      <= 16'h2020;
            seg         <= 7'h7F;
            an          <= 2'b11;
            err         <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CNT_W'(1);
            if (slot_end) begin
                sel <= ~sel;
            end
            if (frame_start) begin
                shadow      <= ascii_in;
                frame_start <= 1'b0;
            end
            if (frame_end) begin
                frame_start <= 1'b1;
            end
            seg <= blank ? 7'h7F : seg_nxt;
            an  <= blank ? 2'b11 : an_nxt;
            err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ascii_seg_display.sv
module tb_ascii_seg_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

    logic        clock;
    logic        reset;
    logic [15:0] ascii_in;
    logic        done;
    logic [6:0]  seg;
    logic [1:0]  an;
    logic        err;

    int total_cnt;
    int pass_cnt;

    typedef struct {
        logic [15:0] ascii;
        logic [6:0]  seg;
        logic [1:0]  an;
        logic        err;
    } vec_t;

    vec_t tbl [1:49];

    ascii_seg_display #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .ascii_in (ascii_in),
        .done     (done),
        .seg      (seg),
        .an       (an),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input int k, input logic [6:0] s,
                       input logic [1:0] a, input logic e);
        total_cnt++;
        if (seg !== s || an !== a || err !== e)
            $display("FAIL %s k=%0d: got seg=%b an=%b err=%b, want seg=%b an=%b err=%b",
                     name, k, seg, an, err, s, a, e);
        else
            pass_cnt++;
    endtask

    task automatic fill_in(input int lo, input int hi, input logic [15:0] a);
        for (int i = lo; i <= hi; i++) tbl[i].ascii = a;
    endtask

    task automatic fill_exp(input int lo, input int hi, input logic [6:0] s,
                            input logic [1:0] a, input logic e);
        for (int i = lo; i <= hi; i++) begin
            tbl[i].seg = s;
            tbl[i].an  = a;
            tbl[i].err = e;
        end
    endtask

    initial begin
        bit          blink_build;
        bit          off;
        logic [6:0]  es;
        logic [1:0]  ea;

        total_cnt = 0;
        pass_cnt  = 0;
`ifdef BLINK_ON_DONE_EN
        blink_build = 1'b1;
`else
        blink_build = 1'b0;
`endif

        // Inputs per edge k (applied before edge k).
        fill_in(1, 12, 16'h3230);   // "20"
        fill_in(13, 20, 16'h3139);  // "19" arrives during a units slot
        fill_in(21, 28, 16'h4135);  // "A5"
        fill_in(29, 36, 16'h3035);  // "05"
        fill_in(37, 49, 16'h202D);  // " -"

        // Output after edge k. Frames latch on edges 1,9,17,...; the output
        // edge right after a latch still shows the previous shadow.
        fill_exp(1, 1, SB, 2'b01, 1'b0);
        fill_exp(2, 4, S2, 2'b01, 1'b0);
        fill_exp(5, 8, S0, 2'b10, 1'b0);
        fill_exp(9, 12, S2, 2'b01, 1'b0);
        fill_exp(13, 16, S0, 2'b10, 1'b0);
        fill_exp(17, 17, S2, 2'b01, 1'b0);
        fill_exp(18, 20, S1, 2'b01, 1'b0);
        fill_exp(21, 24, S9, 2'b10, 1'b0);
        fill_exp(25, 25, S1, 2'b01, 1'b0);
        fill_exp(26, 28, SB, 2'b01, 1'b1);
        fill_exp(29, 32, S5, 2'b10, 1'b1);
        fill_exp(33, 33, SB, 2'b01, 1'b1);
        fill_exp(34, 36, S0, 2'b01, 1'b0);
        fill_exp(37, 40, S5, 2'b10, 1'b0);
        fill_exp(41, 41, S0, 2'b01, 1'b0);
        fill_exp(42, 44, SB, 2'b01, 1'b0);
        fill_exp(45, 48, SD, 2'b10, 1'b0);
        fill_exp(49, 49, SB, 2'b01, 1'b0);

        reset    = 1'b1;
        done     = 1'b0;
        ascii_in = 16'h3230;
        #2;
        chk("reset_state", 0, SB, 2'b11, 1'b0);
        tick();
        tick();
        chk("reset_held", 0, SB, 2'b11, 1'b0);
        reset = 1'b0;

        for (int k = 1; k <= 49; k++) begin
            ascii_in = tbl[k].ascii;
            tick();
            chk("table", k, tbl[k].seg, tbl[k].an, tbl[k].err);
        end

        // Get err=1 with a lit tens digit, then reset between edges.
        ascii_in = 16'h4135;
        for (int k = 50; k <= 59; k++) begin
            tick();
            if (k >= 58) chk("err_before_reset", k, SB, 2'b01, 1'b1);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 0, SB, 2'b11, 1'b0);
        ascii_in = 16'h3337;        // "37"
        done     = 1'b1;
        tick();
        chk("async_reset_held", 0, SB, 2'b11, 1'b0);
        reset = 1'b0;

        // Restart from tens; done=1 blinks only in the blink build.
        // Done drops before edge 53, in the middle of the second off phase.
        for (int k = 1; k <= 72; k++) begin
            if (k == 53) done = 1'b0;
            tick();
            off = blink_build && ((k >= 17 && k <= 32) || (k >= 49 && k <= 52));
            if (((k - 1) % 8) < 4) begin
                es = (k == 1) ? SB : S3;
                ea = 2'b01;
            end else begin
                es = S7;
                ea = 2'b10;
            end
            if (off) begin
                es = SB;
                ea = 2'b11;
            end
            chk("restart_done", k, es, ea, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ascii_seg_display.md
Name: ascii_seg_display

Overview:
- Downstream consumer of the two-digit ASCII down-counter.
- Takes the counter's 16-bit ASCII value (two characters) and its done flag.
- Drives a 2-digit multiplexed, active-low seven-segment display with tear-free frame latching.
- Flags undisplayable characters on err.

Parameters:
- REFRESH_DIV, default 4: clock cycles each digit is lit per scan slot (legal range >=2). One frame is 2*REFRESH_DIV cycles.
- BLINK_DIV, default 2: full frames per blink half-phase. Used only when BLINK_ON_DONE_EN is defined.

Ports:
- clock  in  1: single system clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high reset.
- ascii_in  in  16: [15:8] tens character, [7:0] units character, ASCII.
- done  in  1: counter finished flag.
- seg  out  7: active-low segments, bit order {g,f,e,d,c,b,a}.
- an  out  2: active-low digit enables; an[1] is tens, an[0] is units.
- err  out  1: high while the latched frame holds an illegal character.

Behaviour:
- Reset (asynchronous, takes effect immediately with no clock edge):
  - seg=7'h7F, an=2'b11, err=0.
  - sel=0, refresh count=0, blink state cleared.
  - shadow=16'h2020 (two spaces).
  - frame_start=1.
- Refresh counter: counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and sel toggles (0 = tens, 1 = units).
- Frame latch:
  - On any edge with frame_start=1: shadow <= ascii_in and frame_start <= 0.
  - frame_start is set on the edge where sel toggles 1->0.
  - ascii_in changes inside a frame never reach the display until the next frame.
- Decode (active-low):
  - '0'=1000000, '1'=1111001, '2'=0100100, '3'=0110000, '4'=0011001.
  - '5'=0010010, '6'=0000010, '7'=1111000, '8'=0000000, '9'=0010000.
  - ' ' (0x20) = 1111111 (blank); '-' (0x2D) = 0111111.
  - Any other code: blank, and counts as illegal.
- Output timing:
  - seg, an and err are registered.
  - Their values at edge t+1 reflect sel and shadow at edge t (1-cycle latency).
  - an = 2'b01 when sel=0, and 2'b10 when sel=1.
  - The first lit output appears 2 cycles after reset release: latch edge, then output edge.
- err: registered OR of the illegality of both shadow bytes. It updates together with seg, so it holds for the whole frame.
- done is sampled only by the optional blink logic.
- Simultaneous events:
  - A frame latch and a sel toggle on the same edge are both performed.
  - Reset overrides everything.

Optional Feature:
- Macro: BLINK_ON_DONE_EN.
- With the macro defined, while done=1:
  - A blink counter counts completed frames.
  - After every BLINK_DIV frames a phase bit toggles, starting in the "on" phase.
  - In the "off" phase, an is forced to 2'b11 and seg to 7'h7F. err is unaffected.
  - When done falls, the blink counter and phase clear on that edge, and the next output edge is normal.
- Without the macro: no blink logic is built, done is ignored, and the display is steady.

Test Plan:
- Reset, ascii_in="20", REFRESH_DIV=4:
  - While reset=1: an=11, seg=1111111.
  - After release: an=01, seg=0100100 for 4 cycles; then an=10, seg=1000000 for 4 cycles; the pattern repeats.
- Change "20"->"19" during the units slot: the units slot keeps showing 1000000. The next tens slot shows 1111001, then units shows 0010000.
- ascii_in="A5": tens blank 1111111 and err=1; units shows 0010010. Changing to "05" clears err when the next frame's tens slot appears.
- ascii_in=" -": tens shows 1111111, units shows 0111111, err=0.
- With BLINK_ON_DONE_EN and BLINK_DIV=2, done=1:
  - 2 frames normal, 2 frames with an=11/seg=7F, then normal again.
  - Dropping done mid-off-phase restores output on the next edge.
- Assert reset mid-slot between clock edges: an=11, seg=7F, err=0 immediately. After release, the sequence restarts with the tens digit.
